acc_datapath: RTL and testbench

- Accumulator datapath that consumes the one-hot phase strobes `fetch`/`decode`/`execute` produced by `instruction_cycle_fsm`, and executes one instruction per fetch-decode-execute round.
- Holds the PC, instruction register, accumulator, flags and a small internal data memory.
- Drives the instruction-memory address and reads the instruction word combinationally.
- Sits directly downstream of the control-unit FSM in the course CPU.

---
 rtl/acc_datapath.sv | 175 +++++++++++++++++
 tb/tb_acc_datapath.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/acc_datapath.sv
// Accumulator datapath for the course CPU: executes one instruction per
// fetch/decode/execute round driven by the one-hot strobes of the control FSM.
module acc_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch,
    input  logic                decode,
    input  logic                execute,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [ADDR_W+3:0]   imem_data,
    output logic [ADDR_W-1:0]   pc,
    output logic [ADDR_W+3:0]   ir,
    output logic [DATA_W-1:0]   acc,
    output logic                zero,
    output logic                carry,
    output logic                halted,
    output logic                illegal
);

    localparam int IR_W  = ADDR_W + 4;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LDA  = 4'h2,
        OP_STA  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_JC   = 4'hA,
        OP_HALT = 4'hF
    } opcode_e;

    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic [IR_W-1:0]   ir_q,      ir_d;
    logic [DATA_W-1:0] acc_q,     acc_d;
    logic [DATA_W-1:0] opnd_q,    opnd_d;
    logic              zero_q,    zero_d;
    logic              carry_q,   carry_d;
    logic              halted_q,  halted_d;
    logic              illegal_q, illegal_d;

    logic [DATA_W-1:0] dmem_q [DEPTH];
    logic              dmem_we;

    opcode_e           opcode;
    logic [ADDR_W-1:0] a_field;
    logic [2:0]        phase;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;

    assign opcode  = opcode_e'(ir_q[IR_W-1:ADDR_W]);
    assign a_field = ir_q[ADDR_W-1:0];
    assign phase   = {fetch, decode, execute};
    assign sum     = {1'b0, acc_q} + {1'b0, opnd_q};
    assign diff    = acc_q - opnd_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        pc_d      = pc_q;
        ir_d      = ir_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        dmem_we   = 1'b0;

        // Anything other than exactly one strobe is a no-op.
        if (!halted_q) begin
            unique case (phase)
                3'b100: begin
                    ir_d = imem_data;
                    pc_d = pc_q + ADDR_W'(1);
                end
                3'b010: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR:
                            opnd_d = dmem_q[a_field];
                        default:
                            opnd_d = DATA_W'(a_field);
                    endcase
                end
                3'b001: begin
                    case (opcode)
                        OP_NOP: ;
                        OP_LDI, OP_LDA: begin
                            acc_d  = opnd_q;
                            zero_d = (opnd_q == '0);
                        end
                        OP_STA: dmem_we = 1'b1;
                        OP_ADD: begin
                            acc_d   = sum[DATA_W-1:0];
                            carry_d = sum[DATA_W];
                            zero_d  = (sum[DATA_W-1:0] == '0);
                        end
                        OP_SUB: begin
                            acc_d   = diff;
                            carry_d = (acc_q < opnd_q);
                            zero_d  = (diff == '0);
                        end
                        OP_AND: begin
                            acc_d  = acc_q & opnd_q;
                            zero_d = ((acc_q & opnd_q) == '0);
                        end
                        OP_OR: begin
                            acc_d  = acc_q | opnd_q;
                            zero_d = ((acc_q | opnd_q) == '0);
                        end
                        OP_JMP: pc_d = a_field;
                        OP_JZ:  if (zero_q)  pc_d = a_field;
                        OP_JC:  if (carry_q) pc_d = a_field;
                        OP_HALT: halted_d = 1'b1;
                        default: illegal_d = 1'b1;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            pc_q      <= '0;
            ir_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: the data memory must clear on reset, so it is built from
    // resettable flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                dmem_q[i] <= '0;
            end
        end else if (dmem_we) begin
            dmem_q[a_field] <= acc_q;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign acc       = acc_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_acc_datapath.sv
// Directed bench for acc_datapath: small programs in a combinational ROM,
// each checked against hand-computed register values.
module tb_acc_datapath;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch, decode, execute;
    logic [ADDR_W-1:0] imem_addr;
    logic [ADDR_W+3:0] imem_data;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W+3:0] ir;
    logic [DATA_W-1:0] acc;
    logic              zero, carry, halted, illegal;

    logic [7:0] rom [16];
    int n_tests = 0;
    int n_fail  = 0;

    assign imem_data = rom[imem_addr];

    always #5 clk = ~clk;

    acc_datapath #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch     (fetch),
        .decode    (decode),
        .execute   (execute),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .pc        (pc),
        .ir        (ir),
        .acc       (acc),
        .zero      (zero),
        .carry     (carry),
        .halted    (halted),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read there too.
    task automatic phase(input logic f, input logic d, input logic e);
        fetch = f; decode = d; execute = e;
        @(posedge clk); #1;
        fetch = 1'b0; decode = 1'b0; execute = 1'b0;
    endtask

    task automatic round();
        phase(1'b1, 1'b0, 1'b0);
        phase(1'b0, 1'b1, 1'b0);
        phase(1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pc"},      32'(pc),      32'h0);
        check({tag, " ir"},      32'(ir),      32'h0);
        check({tag, " acc"},     32'(acc),     32'h0);
        check({tag, " zero"},    32'(zero),    32'h0);
        check({tag, " carry"},   32'(carry),   32'h0);
        check({tag, " halted"},  32'(halted),  32'h0);
        check({tag, " illegal"}, 32'(illegal), 32'h0);
    endtask

    initial begin
        reset = 1'b0; fetch = 1'b0; decode = 1'b0; execute = 1'b0;
        clear_rom();
        @(posedge clk); #1;
        do_reset();
        check_all_zero("por");
        check("por imem_addr", 32'(imem_addr), 32'h0);

        // Arithmetic program: LDI 5; STA 0; ADD 0; SUB 0; HALT
        rom[0] = 8'h15; rom[1] = 8'h30; rom[2] = 8'h40; rom[3] = 8'h50; rom[4] = 8'hF0;
        round();
        check("ldi acc", 32'(acc), 32'd5);
        round();
        round();
        check("add acc",   32'(acc),   32'd10);
        check("add carry", 32'(carry), 32'd0);
        round();
        check("sub acc",   32'(acc),   32'd5);
        check("sub carry", 32'(carry), 32'd0);
        check("sub zero",  32'(zero),  32'd0);
        round();
        check("halt halted", 32'(halted), 32'd1);
        check("halt pc",     32'(pc),     32'd5);
        round();
        phase(1'b1, 1'b0, 1'b0);
        check("halted pc",  32'(pc),  32'd5);
        check("halted ir",  32'(ir),  32'hF0);
        check("halted acc", 32'(acc), 32'd5);

        // Reset mid-run: LDI 7; STA 2; then reset during decode of ADD 2 at pc=3
        do_reset();
        clear_rom();
        rom[0] = 8'h17; rom[1] = 8'h32; rom[2] = 8'h42;
        round();
        round();
        phase(1'b1, 1'b0, 1'b0);
        check("pre-reset pc",  32'(pc),  32'd3);
        check("pre-reset acc", 32'(acc), 32'd7);
        reset = 1'b0; decode = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; decode = 1'b0;
        check_all_zero("midrst");

        // Scan data memory with LDA i at address i; also covers pc wrap F->0
        for (int i = 0; i < 16; i++) rom[i] = {4'h2, 4'(i)};
        for (int i = 0; i < 16; i++) begin
            round();
            check($sformatf("dmem[%0d]", i), 32'(acc), 32'h0);
        end
        check("wrap pc", 32'(pc), 32'h0);

        // Flag boundaries and branches
        do_reset();
        clear_rom();
        rom[0] = 8'h11; rom[1] = 8'h31; rom[2] = 8'h10; rom[3] = 8'h51;
        rom[4] = 8'h41; rom[5] = 8'h51; rom[6] = 8'h9A; rom[7] = 8'h10;
        rom[8] = 8'h9A; rom[10] = 8'h8C; rom[12] = 8'hAE; rom[14] = 8'h00;
        rom[15] = 8'h80;
        round(); round(); round(); round();
        check("pre acc",   32'(acc),   32'hFF);
        check("pre carry", 32'(carry), 32'd1);
        round();
        check("ff+1 acc",   32'(acc),   32'h00);
        check("ff+1 carry", 32'(carry), 32'd1);
        check("ff+1 zero",  32'(zero),  32'd1);
        round();
        check("0-1 acc",   32'(acc),   32'hFF);
        check("0-1 carry", 32'(carry), 32'd1);
        check("0-1 zero",  32'(zero),  32'd0);
        round();
        check("jz nt addr", 32'(imem_addr), 32'h7);
        round();
        check("ldi0 zero", 32'(zero), 32'd1);
        round();
        check("jz t addr", 32'(imem_addr), 32'hA);
        round();
        check("jmp c pc", 32'(pc), 32'hC);
        round();
        check("jc pc", 32'(pc), 32'hE);
        round();
        check("nop pc", 32'(pc), 32'hF);
        phase(1'b1, 1'b0, 1'b0);
        check("fetch wrap pc", 32'(pc), 32'h0);
        phase(1'b0, 1'b1, 1'b0);
        phase(1'b0, 1'b0, 1'b1);
        check("jmp 0 pc", 32'(pc), 32'h0);
        check("jmp 0 ir", 32'(ir), 32'h80);

        // Illegal opcode: LDI 3; 0xC3; LDI 2
        do_reset();
        clear_rom();
        rom[0] = 8'h13; rom[1] = 8'hC3; rom[2] = 8'h12;
        round();
        round();
        check("ill acc",     32'(acc),     32'd3);
        check("ill pc",      32'(pc),      32'd2);
        check("ill zero",    32'(zero),    32'd0);
        check("ill carry",   32'(carry),   32'd0);
        check("ill illegal", 32'(illegal), 32'd1);
        round();
        check("post-ill acc",     32'(acc),     32'd2);
        check("post-ill illegal", 32'(illegal), 32'd1);

        // Non-one-hot phases leave state alone
        phase(1'b1, 1'b1, 1'b0);
        phase(1'b0, 1'b0, 1'b0);
        phase(1'b0, 1'b0, 1'b0);
        phase(1'b0, 1'b0, 1'b0);
        phase(1'b1, 1'b0, 1'b1);
        check("nohot ir",  32'(ir),  32'h12);
        check("nohot pc",  32'(pc),  32'd3);
        check("nohot acc", 32'(acc), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
